// File: rtl/pg_rca_seq_pkg.sv
// pg_rca_seq_pkg: shared states, slice width and index sizing for the nibble-serial adder
package pg_rca_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int SLICE_W = 4;
    function automatic int idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction
endpackage

// File: rtl/pg_rca4_cin.sv
// pg_rca4_cin: combinational 4-bit propagate/generate ripple-carry slice with carry-in
module pg_rca4_cin (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] p, g;
    logic c1, c2, c3;
    assign p = a_i ^ b_i;
    assign g = a_i & b_i;
    assign c1 = g[0] | (p[0] & cin_i);
    assign c2 = g[1] | (p[1] & c1);
    assign c3 = g[2] | (p[2] & c2);
    assign cout_o = g[3] | (p[3] & c3);
    assign sum_o = p ^ {c3, c2, c1, cin_i};
endmodule

// File: rtl/pg_rca_seq_adder.sv
// pg_rca_seq_adder: WIDTH-bit unsigned adder reusing one 4-bit slice, one nibble per clock, LSB first
module pg_rca_seq_adder
    import pg_rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW = idx_w(NSLICE);
    state_e state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0] res_q, res_d;
    logic carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0] sum;
    logic cout;
    int base;
    assign base = SLICE_W * int'(idx_q);
    pg_rca4_cin u_slice (
        .a_i(a_q[base +: SLICE_W]),
        .b_i(b_q[base +: SLICE_W]),
        .cin_i(carry_q),
        .sum_o(sum),
        .cout_o(cout)
    );
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        res_d = res_q;
        carry_d = carry_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d = a;
                b_d = b;
                res_d = '0;
                carry_d = 1'b0;
                idx_d = '0;
                state_d = RUN;
            end
            RUN: begin
                res_d[base +: SLICE_W] = sum;
                carry_d = cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(NSLICE - 1)) begin
                    res_d[WIDTH] = cout;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            carry_q <= 1'b0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            res_q <= res_d;
            carry_q <= carry_d;
            idx_q <= idx_d;
        end
    end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy = state_q != IDLE;
    assign out = res_q;
endmodule

// File: tb/tb_pg_rca_seq_adder.sv
// tb_pg_rca_seq_adder: directed and random checks of the nibble-serial adder at WIDTH 4/8/16/32
module tb_pg_rca_seq_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [31:0] a = '0, b = '0;
    logic [3:0] iv = '0, ordy = '0, ir, ov, bz;
    logic [32:0] outx [4];
    int errs = 0, nchk = 0;
    for (genvar g = 0; g < 4; g++) begin : u
        localparam int W = 4 << g;
        logic [W:0] o;
        pg_rca_seq_adder #(.WIDTH(W)) dut (
            .clk(clk), .rst(rst),
            .in_valid(iv[g]), .in_ready(ir[g]),
            .a(a[W-1:0]), .b(b[W-1:0]),
            .out_valid(ov[g]), .out_ready(ordy[g]),
            .out(o), .busy(bz[g])
        );
        assign outx[g] = 33'(o);
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [32:0] ref_sum(input int s, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] m = (33'd1 << (4 << s)) - 33'd1;
        return (33'(x) & m) + (33'(y) & m);
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(input int s, output int lat);
        lat = 0;
        while (!ov[s] && lat < 64) begin
            tick();
            lat++;
        end
    endtask
    task automatic run(input int s, input logic [31:0] x, input logic [31:0] y, input int stall);
        int lat;
        logic [32:0] e;
        e = ref_sum(s, x, y);
        chk("in_ready", 64'(ir[s]), 64'd1);
        a = x;
        b = y;
        iv[s] = 1'b1;
        tick();
        iv[s] = 1'b0;
        a = $urandom;
        b = $urandom;
        chk("busy", {62'd0, bz[s], ir[s]}, 64'd2);
        wait_done(s, lat);
        chk("latency", 64'(lat), 64'(1 << s));
        chk("sum", 64'(outx[s]), 64'(e));
        repeat (stall) begin
            tick();
            chk("hold", 64'({ov[s], outx[s]}), 64'({1'b1, e}));
        end
        ordy[s] = 1'b1;
        tick();
        ordy[s] = 1'b0;
        chk("release", {61'd0, ov[s], ir[s], bz[s]}, 64'd2);
        chk("keep", 64'(outx[s]), 64'(e));
    endtask
    initial begin
        int lat;
        logic [31:0] x, y;
        repeat (2) tick();
        for (int s = 0; s < 4; s++)
            chk("reset", 64'({ov[s], ir[s], bz[s], outx[s]}), 64'({3'b010, 33'd0}));
        rst = 1'b0;
        ordy = 4'hF;
        repeat (2) tick();
        ordy = 4'h0;
        chk("ordy_idle", 64'({ov, bz}), 64'd0);
        run(2, 32'hFFFF, 32'h0001, 0);
        run(2, 32'h1234, 32'h4321, 3);
        run(2, 32'hFFFF, 32'hFFFF, 0);
        run(2, 32'h0000, 32'h0000, 0);
        a = 32'h1111;
        b = 32'h2222;
        iv[2] = 1'b1;
        tick();
        a = 32'hABCD;
        b = 32'h1234;
        repeat (4) begin
            chk("no_accept", 64'(ir[2]), 64'd0);
            tick();
        end
        chk("first", 64'({ov[2], outx[2]}), 64'({1'b1, ref_sum(2, 32'h1111, 32'h2222)}));
        ordy[2] = 1'b1;
        tick();
        ordy[2] = 1'b0;
        chk("idle_again", 64'(ir[2]), 64'd1);
        tick();
        iv[2] = 1'b0;
        wait_done(2, lat);
        chk("second_lat", 64'(lat), 64'd4);
        chk("second", 64'(outx[2]), 64'(ref_sum(2, 32'hABCD, 32'h1234)));
        ordy[2] = 1'b1;
        tick();
        ordy[2] = 1'b0;
        a = 32'h5555;
        b = 32'h1111;
        iv[2] = 1'b1;
        tick();
        iv[2] = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid", 64'({ov[2], ir[2], bz[2], outx[2]}), 64'({3'b010, 33'd0}));
        #1;
        rst = 1'b0;
        tick();
        run(2, 32'h00FF, 32'h0001, 1);
        for (int s = 0; s < 4; s++)
            for (int n = 0; n < 250; n++) begin
                x = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                y = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                run(s, x, y, $urandom_range(0, 3));
            end
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/pg_rca_seq_adder.md
Name: pg_rca_seq_adder

Overview:
- Multi-cycle unsigned adder for WIDTH-bit operands built around a single 4-bit propagate/generate ripple-carry slice with carry-in.
- Processes one 4-bit nibble per clock, LSB first, and keeps the inter-slice carry in a register.
- Uses valid/ready handshakes on input and output.
- Lets wide additions reuse one small slice, trading latency for area, in the approximate-arithmetic evaluation datapath.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived number of slice passes; not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  unsigned operand A; sampled on input handshake
- b  input  WIDTH  unsigned operand B; sampled on input handshake
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out  output  WIDTH+1  unsigned sum; bit WIDTH is the carry-out
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset values, asynchronous on rst=1:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out=0, carry register=0, slice index=0, operand registers=0.
- States: IDLE, RUN, DONE (encoded in package).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a and b, clear carry and result, set index=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice adds a_reg[4k+3:4k] + b_reg[4k+3:4k] + carry_reg, where k=index.
  - Slice output: sum[3:0] written to result[4k+3:4k]; cout written to carry_reg.
  - Per-slice carry: cout = g | (p & cin), with p=a^b and g=a&b per bit, rippled through 4 bits.
  - index increments each cycle.
  - When index==NSLICE-1: also write result[WIDTH]=cout and go to DONE.
- DONE:
  - out_valid=1; out holds the registered result and stays stable while out_valid&!out_ready.
  - On out_ready: go to IDLE, out_valid=0 next cycle, out keeps its last value.
- Latency: input handshake at edge N; out_valid high after edge N+NSLICE. For WIDTH=16, four RUN cycles. Throughput is one result per NSLICE+2 cycles minimum.
- No overlap: in_ready=0 in RUN and DONE. Input changes while not ready are ignored.
- Width rule: the result is exact, out = a + b with no truncation. The maximum (2^WIDTH-1)*2 fits in WIDTH+1 bits.
- out_ready asserted outside DONE has no effect.
- Reset mid-operation: the in-flight operation is abandoned, no partial result is presented, and the block returns to IDLE.
- Back-to-back: an out_ready handshake in DONE and a new in_valid are serviced on consecutive cycles (DONE→IDLE→RUN). No combinational path from out_ready to in_ready.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Package pg_rca_seq_pkg:
  - state enum {IDLE, RUN, DONE};
  - SLICE_W=4 constant;
  - function computing the index width, clog2(NSLICE) with a minimum of 1.
- Sub-module pg_rca4_cin: combinational 4-bit pg ripple-carry slice.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], cout.
  - Instantiated once; the controller muxes nibbles into it by index.

Test Plan:
- WIDTH=16: a=0xFFFF, b=0x0001 → carry ripples through all 4 slices; out_valid exactly 4 cycles after handshake; out=0x10000.
- WIDTH=16: a=0x1234, b=0x4321 → out=0x05555; out held stable for 3 cycles with out_ready=0; out_valid drops the cycle after out_ready=1.
- WIDTH=16: a=0xFFFF, b=0xFFFF → out=0x1FFFE; then a=0, b=0 back-to-back → out=0x00000, with the carry register confirmed cleared between operations.
- in_valid held high with a/b changing during RUN → in_ready=0; the second operand pair is accepted only after DONE→IDLE and produces its own correct sum.
- rst pulsed during RUN, second slice → out_valid=0, in_ready=1, state IDLE immediately; a new op a=0x00FF, b=0x0001 → out=0x00100.
- Random 1000 pairs at WIDTH=4, 8, 16, 32 with random out_ready stalls → every out equals a+b, exactly one result per accepted input, latency NSLICE.
